// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types for the pipeline sequencer
//   regbits_t    : 5-bit register index
//   word_t       : 32-bit data word (performance counters)
//   pipe_state_t : sequencer FSM state
package pipe_ctrl_pkg;
   typedef logic [4:0]  regbits_t;
   typedef logic [31:0] word_t;
   typedef enum logic [1:0] {RUN, DWAIT, DRAIN, HALTED} pipe_state_t;
endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: hazard inputs and latch-control outputs of the pipeline sequencer
//   inputs  : ihit, dhit, mem_dREN, mem_dWEN, id_rs, id_rt, ex_dREN, ex_regDst, ex_pcsrc, ex_halt
//   outputs : pc_en, *_en, *_flush, halt, stall_cnt, flush_cnt
interface pipe_ctrl_if;
   import pipe_ctrl_pkg::*;
   logic     ihit, dhit, mem_dREN, mem_dWEN, ex_dREN, ex_pcsrc, ex_halt;
   regbits_t id_rs, id_rt, ex_regDst;
   logic     pc_en, ifid_en, idex_en, exmem_en, memwb_en;
   logic     ifid_flush, idex_flush, exmem_flush, halt;
   word_t    stall_cnt, flush_cnt;
   modport master (
      output ihit, dhit, mem_dREN, mem_dWEN, ex_dREN, ex_pcsrc, ex_halt, id_rs, id_rt, ex_regDst,
      input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush,
      input  halt, stall_cnt, flush_cnt
   );
   modport slave (
      input  ihit, dhit, mem_dREN, mem_dWEN, ex_dREN, ex_pcsrc, ex_halt, id_rs, id_rt, ex_regDst,
      output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush,
      output halt, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/load_use_detect.sv
// load_use_detect: flags a decode-stage source that depends on the load in execute
//   ex_dREN, ex_regDst, id_rs, id_rt -> lu_hazard (register 0 never hazards)
module load_use_detect
   import pipe_ctrl_pkg::*;
(
   input  logic     ex_dREN,
   input  regbits_t ex_regDst,
   input  regbits_t id_rs,
   input  regbits_t id_rt,
   output logic     lu_hazard
);
   assign lu_hazard = ex_dREN && ex_regDst != '0 && (ex_regDst == id_rs || ex_regDst == id_rt);
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: five-stage pipeline sequencer (latch enables/flushes, PC enable, halt drain)
//   CLK, RST : clock, synchronous active-high reset
//   bus      : pipe_ctrl_if.slave, hazard inputs and Mealy latch controls, Moore halt
//   PIPE_PERF_EN defined builds saturating stall/flush counters, otherwise they read 0
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int DRAIN_CYCLES = 2
) (
   input logic        CLK,
   input logic        RST,
   pipe_ctrl_if.slave bus
);
   localparam int CW = $clog2(DRAIN_CYCLES + 1);
   pipe_state_t   r_state, w_next;
   logic [CW-1:0] r_cnt, w_cnt;
   logic          r_halt, w_lu, w_dwait, w_stall;
   logic          w_pc, w_ifid, w_idex, w_exmem, w_memwb, w_ifid_fl, w_idex_fl;
   load_use_detect u_lu (
      .ex_dREN   (bus.ex_dREN),
      .ex_regDst (bus.ex_regDst),
      .id_rs     (bus.id_rs),
      .id_rt     (bus.id_rt),
      .lu_hazard (w_lu)
   );
   assign w_dwait = (bus.mem_dREN || bus.mem_dWEN) && !bus.dhit;
   // DWAIT only waits on dhit; the request lines are ignored there
   assign w_stall = r_state == DWAIT ? !bus.dhit : w_dwait;
   always_comb begin
      w_next    = r_state;
      w_cnt     = r_cnt;
      w_pc      = 1'b0;
      w_ifid    = 1'b0;
      w_idex    = 1'b0;
      w_exmem   = 1'b0;
      w_memwb   = 1'b0;
      w_ifid_fl = 1'b0;
      w_idex_fl = 1'b0;
      if (!RST) begin
         case (r_state)
            RUN, DWAIT: begin
               if (w_stall) w_next = DWAIT;
               else begin
                  w_next  = RUN;
                  w_exmem = 1'b1;
                  w_memwb = 1'b1;
                  w_idex  = 1'b1;
                  if (r_state == RUN && bus.ex_halt) begin
                     w_ifid    = 1'b1;
                     w_ifid_fl = 1'b1;
                     w_idex_fl = 1'b1;
                     w_cnt     = CW'(DRAIN_CYCLES - 1);
                     w_next    = DRAIN;
                  end else if (bus.ex_pcsrc) begin
                     w_pc      = 1'b1;
                     w_ifid    = 1'b1;
                     w_ifid_fl = 1'b1;
                     w_idex_fl = 1'b1;
                  end else if (w_lu) w_idex_fl = 1'b1;
                  else begin
                     w_pc      = bus.ihit;
                     w_ifid    = 1'b1;
                     w_ifid_fl = !bus.ihit;
                  end
               end
            end
            DRAIN: begin
               if (!w_dwait) begin
                  w_ifid    = 1'b1;
                  w_idex    = 1'b1;
                  w_ifid_fl = 1'b1;
                  w_idex_fl = 1'b1;
                  w_exmem   = 1'b1;
                  w_memwb   = 1'b1;
                  if (r_cnt == '0) w_next = HALTED;
                  else w_cnt = r_cnt - CW'(1);
               end
            end
            default: ;
         endcase
      end
   end
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= RUN;
         r_cnt   <= '0;
         r_halt  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt;
         r_halt  <= w_next == HALTED;
      end
   end
   assign bus.pc_en       = w_pc;
   assign bus.ifid_en     = w_ifid;
   assign bus.idex_en     = w_idex;
   assign bus.exmem_en    = w_exmem;
   assign bus.memwb_en    = w_memwb;
   assign bus.ifid_flush  = w_ifid_fl;
   assign bus.idex_flush  = w_idex_fl;
   assign bus.exmem_flush = 1'b0;
   assign bus.halt        = r_halt;
`ifdef PIPE_PERF_EN
   word_t r_stall, r_flush;
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_stall <= '0;
         r_flush <= '0;
      end else begin
         if (!w_pc && r_state != HALTED && r_stall != '1) r_stall <= r_stall + 32'd1;
         if (w_idex_fl && r_flush != '1) r_flush <= r_flush + 32'd1;
      end
   end
   assign bus.stall_cnt = r_stall;
   assign bus.flush_cnt = r_flush;
`else
   assign bus.stall_cnt = '0;
   assign bus.flush_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: table vectors, corner sequences and random stimulus against a reference model
module tb_pipe_ctrl;
   import pipe_ctrl_pkg::*;
   localparam int DC = 2;
   localparam logic [7:0] ALL = 8'b11111_000, BR = 8'b11111_110, LU = 8'b00111_010;
   localparam logic [7:0] MISS = 8'b01111_100, DRN = 8'b01111_110, NONE = 8'b0;
   typedef struct {
      logic rst, ihit, dhit, dren, dwen, exdren, pcsrc, hlt;
      logic [4:0] rs, rt, dst;
      logic [7:0] exp;
   } vec_t;
   logic CLK = 1'b0;
   logic RST;
   always #5 CLK = ~CLK;
   pipe_ctrl_if bus ();
   pipe_ctrl #(.DRAIN_CYCLES(DC)) dut (.CLK(CLK), .RST(RST), .bus(bus));
   int n_tests = 0, n_fail = 0;
   int m_drain = 0;
   bit m_wait = 0, m_halted = 0;
   longint m_stall = 0, m_flush = 0;
   vec_t tab[11];
   task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", n, $time, got, exp);
      end
   endtask
   function automatic logic [7:0] outs();
      return {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
              bus.ifid_flush, bus.idex_flush, bus.exmem_flush};
   endfunction
   function automatic bit m_frozen();
      return m_wait ? !bus.dhit : ((bus.mem_dREN | bus.mem_dWEN) & !bus.dhit);
   endfunction
   // expected latch controls from the priority rules, given model state and current inputs
   function automatic logic [7:0] m_out();
      if (RST || m_halted || m_frozen()) return NONE;
      if (m_drain > 0 || (!m_wait && bus.ex_halt)) return DRN;
      if (bus.ex_pcsrc) return BR;
      if (bus.ex_dREN && bus.ex_regDst != 0 &&
          (bus.ex_regDst == bus.id_rs || bus.ex_regDst == bus.id_rt)) return LU;
      return bus.ihit ? ALL : MISS;
   endfunction
   task automatic m_step(input logic [7:0] o);
      bit fr;
      fr = m_frozen();
      if (RST) begin
         m_drain = 0; m_wait = 0; m_halted = 0; m_stall = 0; m_flush = 0;
      end else if (!m_halted) begin
         if (!o[7] && m_stall < 64'hFFFF_FFFF) m_stall++;
         if (o[1] && m_flush < 64'hFFFF_FFFF) m_flush++;
         if (fr) begin
            if (m_drain == 0) m_wait = 1;
         end else begin
            if (m_drain > 0) begin
               m_drain--;
               if (m_drain == 0) m_halted = 1;
            end else if (!m_wait && bus.ex_halt) m_drain = DC;
            m_wait = 0;
         end
      end
   endtask
   task automatic check_now(input string tag);
      logic [7:0] o;
      o = m_out();
      chk({tag, "_ctl"}, {24'd0, outs()}, {24'd0, o});
      chk({tag, "_halt"}, {31'd0, bus.halt}, {31'd0, m_halted});
`ifdef PIPE_PERF_EN
      chk({tag, "_stall"}, bus.stall_cnt, m_stall[31:0]);
      chk({tag, "_flush"}, bus.flush_cnt, m_flush[31:0]);
`else
      chk({tag, "_stall"}, bus.stall_cnt, 32'd0);
      chk({tag, "_flush"}, bus.flush_cnt, 32'd0);
`endif
      m_step(o);
   endtask
   task automatic tick(input string tag);
      @(negedge CLK);
      check_now(tag);
      @(posedge CLK);
      #1;
   endtask
   task automatic idle();
      RST = 1'b0; bus.ihit = 1'b1; bus.dhit = 1'b1; bus.mem_dREN = 1'b0; bus.mem_dWEN = 1'b0;
      bus.ex_dREN = 1'b0; bus.ex_pcsrc = 1'b0; bus.ex_halt = 1'b0;
      bus.id_rs = 5'd1; bus.id_rt = 5'd2; bus.ex_regDst = 5'd3;
   endtask
   task automatic drive(input vec_t v);
      RST = v.rst; bus.ihit = v.ihit; bus.dhit = v.dhit; bus.mem_dREN = v.dren; bus.mem_dWEN = v.dwen;
      bus.ex_dREN = v.exdren; bus.ex_pcsrc = v.pcsrc; bus.ex_halt = v.hlt;
      bus.id_rs = v.rs; bus.id_rt = v.rt; bus.ex_regDst = v.dst;
   endtask
   task automatic do_reset();
      idle();
      RST = 1'b1;
      tick("rst");
      RST = 1'b0;
   endtask
   int edges;
   initial begin
      tab[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, ALL};
      tab[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd1, 5'd5, 5'd5, LU};
      tab[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd7, 5'd2, 5'd7, LU};
      tab[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, ALL};
      tab[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 5'd5, 5'd5, ALL};
      tab[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd5, 5'd5, 5'd5, BR};
      tab[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, MISS};
      tab[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd4, 5'd1, 5'd4, LU};
      tab[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, ALL};
      tab[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd1, 5'd2, 5'd3, NONE};
      tab[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, ALL};
      idle();
      RST = 1'b1;
      @(posedge CLK);
      #1;
      do_reset();
      for (int i = 0; i < 11; i++) begin
         drive(tab[i]);
         @(negedge CLK);
         chk($sformatf("vec%0d", i), {24'd0, outs()}, {24'd0, tab[i].exp});
         check_now($sformatf("vec%0d_m", i));
         @(posedge CLK);
         #1;
      end
      do_reset();
      bus.mem_dREN = 1'b1; bus.dhit = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         chk("dwait_frozen", {24'd0, outs()}, {24'd0, NONE});
         check_now("dwait");
         @(posedge CLK);
         #1;
      end
      bus.dhit = 1'b1;
      @(negedge CLK);
      chk("dwait_release", {24'd0, outs()}, {24'd0, ALL});
      check_now("dwait_rel");
      @(posedge CLK);
      #1;
      idle();
      tick("dwait_after");
      do_reset();
      bus.ex_halt = 1'b1;
      tick("halt_det");
      bus.ex_halt = 1'b0;
      edges = 1;
      while (!bus.halt && edges < 20) begin
         tick("drain");
         edges++;
      end
      chk("halt_edges", edges, 3);
      bus.ihit = 1'b0; bus.ex_pcsrc = 1'b1;
      tick("halted_hold");
      do_reset();
      bus.ex_halt = 1'b1;
      tick("halt_det2");
      bus.ex_halt = 1'b0;
      tick("drain2");
      bus.mem_dWEN = 1'b1; bus.dhit = 1'b0;
      tick("drain_miss");
      tick("drain_miss");
      idle();
      edges = 4;
      while (!bus.halt && edges < 20) begin
         tick("drain2b");
         edges++;
      end
      chk("halt_edges_miss", edges, 5);
      do_reset();
      bus.ex_halt = 1'b1;
      tick("halt_det3");
      idle();
      RST = 1'b1;
      tick("rst_drain");
      RST = 1'b0;
      chk("rst_drain_halt", {31'd0, bus.halt}, 32'd0);
      chk("rst_drain_stall", bus.stall_cnt, 32'd0);
      @(negedge CLK);
      chk("rst_drain_run", {24'd0, outs()}, {24'd0, ALL});
      check_now("rst_drain_run");
      @(posedge CLK);
      #1;
      do_reset();
      bus.ihit = 1'b0;
      for (int i = 0; i < 4; i++) tick("perf_miss");
      bus.ihit = 1'b1; bus.ex_pcsrc = 1'b1;
      tick("perf_br");
`ifdef PIPE_PERF_EN
      chk("perf_stall", bus.stall_cnt, 32'd4);
      chk("perf_flush", bus.flush_cnt, 32'd1);
`else
      chk("perf_stall", bus.stall_cnt, 32'd0);
      chk("perf_flush", bus.flush_cnt, 32'd0);
`endif
      for (int i = 0; i < 3000; i++) begin
         RST = ($urandom % 60) == 0;
         bus.ihit = ($urandom % 4) != 0;
         bus.dhit = ($urandom % 3) != 0;
         bus.mem_dREN = ($urandom % 4) == 0;
         bus.mem_dWEN = ($urandom % 8) == 0;
         bus.ex_dREN = ($urandom % 2) == 0;
         bus.ex_pcsrc = ($urandom % 6) == 0;
         bus.ex_halt = ($urandom % 40) == 0;
         bus.id_rs = 5'($urandom_range(0, 3));
         bus.id_rt = 5'($urandom_range(0, 3));
         bus.ex_regDst = 5'($urandom_range(0, 3));
         tick("rand");
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
